seq_detect_arbiter: RTL
=======================

Name: seq_detect_arbiter

Overview:
- Time-multiplexes one shared serial pattern matcher (default pattern 1010, Mealy, non-overlapping) across NCH serial bit-stream requesters.
- A round-robin arbiter grants one requester per cycle, and that requester's bit is consumed on the clock edge.
- Per-channel match context (history window and fill count) is saved and restored, so each stream is detected independently.
- Sits between several serial sources and the downstream match-event consumer.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- PAT_W, 4, pattern length in bits (2..8).
- PATTERN, 4'b1010, target sequence. MSB is the oldest bit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ch_en  input  NCH  per-channel enable. A low bit masks the request and clears that channel's context.
- req  input  NCH  per-channel bit-valid.
- bit_in  input  NCH  per-channel serial data bit, sampled when its gnt is high.
- gnt  output  NCH  one-hot grant. Combinational from req, ch_en and the round-robin pointer. The bit is consumed at the clock edge.
- match  output  1  registered one-cycle pulse when the granted channel completes the pattern.
- match_ch  output  $clog2(NCH)  channel index of the match. Valid only while match=1, 0 otherwise.
- busy  output  1  registered. High if any enabled channel holds a nonzero fill count.

Behaviour:
- Reset (asynchronous, reset=1):
  - rr_ptr=0, every channel's hist=0 and fill=0.
  - match=0, match_ch=0, busy=0. gnt=0 while reset is high.
- Arbitration:
  - Eligible set = req & ch_en.
  - Grant the first eligible channel, searching from rr_ptr upward and wrapping modulo NCH.
  - At most one gnt bit is high.
  - If nothing is eligible: gnt=0 and rr_ptr holds.
- Pointer update: on a grant to channel k, rr_ptr <= (k+1) mod NCH at the edge. Fairness: any continuously requesting channel is granted within NCH cycles.
- Context per channel: hist[PAT_W-1:0] (shift window) and fill[$clog2(PAT_W+1)-1:0], saturating at PAT_W.
- Match path on a grant to channel k, at the edge:
  - new_hist = {hist[k][PAT_W-2:0], bit_in[k]}.
  - new_fill = min(fill[k]+1, PAT_W).
  - hit = (new_fill==PAT_W) && (new_hist==PATTERN).
  - match <= hit, match_ch <= hit ? k : 0.
  - Latency is one cycle from the grant edge to the match pulse.
- Non-overlapping (default): on hit, hist[k] <= 0 and fill[k] <= 0. Otherwise hist[k] <= new_hist and fill[k] <= new_fill.
- Ungranted channels keep their context unchanged.
- ch_en[k] low: hist[k] and fill[k] are cleared at the next edge. This takes priority over any other update of channel k, which cannot be granted anyway.
- No grant in a cycle: match <= 0.
- Reset mid-stream: all partial contexts are lost. Detection restarts from an empty window.
- Simultaneous requests: only the granted bit is consumed. Ungranted sources must hold req and bit_in stable until granted.

Optional Feature:
- Macro: OVERLAP_EN.
- Defined: on hit, context becomes hist[k] <= new_hist and fill[k] <= PAT_W-1, so suffix/prefix overlap is detected. Example: PATTERN 1010 with stream 1010101 gives two matches.
- Undefined: non-overlapping clear-on-hit as above. The same stream 1010101 gives one match.

Decomposition:
- Package seq_detect_pkg holds:
  - NCH_MAX=8 and PAT_W_MAX=8.
  - typedef ch_ctx_t (struct: hist, fill).
  - Function rr_pick(req_mask, ptr), returning the one-hot grant.
- One sub-module, pattern_match_core: purely combinational. Inputs are hist, fill and bit. Outputs are new_hist, new_fill and hit, with OVERLAP_EN handling included.
- The top level owns the arbiter, rr_ptr, the context array and the output registers.

Test Plan:
- Single channel 0, ch_en=4'b0001, req0=1 steady, bits 1,0,1,0 → match=1, match_ch=0 in the cycle after the 4th grant. The next bits 1,0 produce no match.
- Stream 1010101 on channel 1 only → one match without OVERLAP_EN. With OVERLAP_EN, two matches, after the 4th and 6th grants.
- req=4'b1111 held, rr_ptr=0 → gnt sequence 0001, 0010, 0100, 1000, 0001. Channel 2 fed 1010 across its grants → match_ch=2 after its 4th grant, while the other channels are unaffected.
- Interleaved contexts: channel 0 fed 1,0,1 and channel 3 fed 0,0,0; then channel 0 fed 0 → match_ch=0. Channel 3 has no match and fill=3.
- Deassert ch_en[1] after channel 1 has received 1,0,1; re-enable it and feed 0 → no match (context cleared). Then 1,0,1,0 → match.
- Assert reset during a partial 101 on channel 0 → gnt=0, match=0, busy=0 immediately. After release, 0 → no match. Then 1010 → match.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared limits, context type and round-robin pick for seq_detect_arbiter
package seq_detect_pkg;

  localparam int NCH_MAX    = 8;
  localparam int PAT_W_MAX  = 8;
  localparam int PTR_MAX_W  = $clog2(NCH_MAX);
  localparam int FILL_MAX_W = $clog2(PAT_W_MAX + 1);

  typedef struct packed {
    logic [PAT_W_MAX-1:0]  hist;
    logic [FILL_MAX_W-1:0] fill;
  } ch_ctx_t;

  // First set bit of req_mask at or after ptr, wrapping; unused upper mask bits must be zero
  function automatic logic [NCH_MAX-1:0] rr_pick(input logic [NCH_MAX-1:0]   req_mask,
                                                 input logic [PTR_MAX_W-1:0] ptr);
    logic [NCH_MAX-1:0]   pick;
    logic                 found;
    logic [PTR_MAX_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NCH_MAX; i++) begin
      idx = ptr + PTR_MAX_W'(i);
      if (!found && req_mask[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - combinational window step and hit detect; OVERLAP_EN keeps the window on a hit
module pattern_match_core #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int             FILL_W  = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-2:0]  hist_i,
  input  logic [FILL_W-1:0] fill_i,
  input  logic              bit_i,
  output logic [PAT_W-2:0]  new_hist_o,
  output logic [FILL_W-1:0] new_fill_o,
  output logic              hit_o
);

  // The oldest window bit is shifted out on every consume, so only the newest
  // PAT_W-1 bits are carried between grants; the full window exists only here.
  logic [PAT_W-1:0]  window;
  logic [FILL_W-1:0] fill_inc;

  // Shift in the new bit, saturate the fill count and compare against the pattern
  always_comb begin
    window   = {hist_i, bit_i};
    fill_inc = (fill_i == FILL_W'(PAT_W)) ? fill_i : fill_i + FILL_W'(1);
    hit_o    = (fill_inc == FILL_W'(PAT_W)) && (window == PATTERN);
`ifdef OVERLAP_EN
    new_hist_o = window[PAT_W-2:0];
    new_fill_o = hit_o ? FILL_W'(PAT_W - 1) : fill_inc;
`else
    new_hist_o = hit_o ? '0 : window[PAT_W-2:0];
    new_fill_o = hit_o ? '0 : fill_inc;
`endif
  end

endmodule

// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - round-robin shared serial pattern matcher with per-channel saved context
module seq_detect_arbiter
  import seq_detect_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         bit_in,
  output logic [NCH-1:0]         gnt,
  output logic                   match,
  output logic [$clog2(NCH)-1:0] match_ch,
  output logic                   busy
);

  localparam int CH_W   = $clog2(NCH);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PAT_W-2:0]   hist_q [NCH];
  logic [PAT_W-2:0]   hist_d [NCH];
  logic [FILL_W-1:0]  fill_q [NCH];
  logic [FILL_W-1:0]  fill_d [NCH];
  logic               match_q, match_d;
  logic [CH_W-1:0]    match_ch_q, match_ch_d;
  logic               busy_q, busy_d;

  logic [NCH-1:0]     eligible;
  logic [NCH_MAX-1:0] pick;
  logic               gnt_any;
  logic [CH_W-1:0]    gnt_idx;
  logic [PAT_W-2:0]   core_hist;
  logic [FILL_W-1:0]  core_fill;
  logic               core_hit;

  // Eligibility and round-robin pick; grant is held low while reset is asserted
  always_comb begin
    eligible = req & ch_en & {NCH{~reset}};
    pick     = rr_pick(NCH_MAX'(eligible), PTR_MAX_W'(rr_ptr_q));
    gnt      = pick[NCH-1:0];
    gnt_any  = |pick;
    gnt_idx  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick[i]) gnt_idx = CH_W'(i);
    end
  end

  pattern_match_core #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .FILL_W (FILL_W)
  ) u_core (
    .hist_i    (hist_q[gnt_idx]),
    .fill_i    (fill_q[gnt_idx]),
    .bit_i     (bit_in[gnt_idx]),
    .new_hist_o(core_hist),
    .new_fill_o(core_fill),
    .hit_o     (core_hit)
  );

  // Context write-back for the granted channel, disable clears, pointer advance and output pulses
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    match_d    = 1'b0;
    match_ch_d = '0;
    busy_d     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      hist_d[i] = hist_q[i];
      fill_d[i] = fill_q[i];
      if (!ch_en[i]) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end else if (gnt_any && (gnt_idx == CH_W'(i))) begin
        hist_d[i] = core_hist;
        fill_d[i] = core_fill;
      end
      if (ch_en[i] && (fill_d[i] != '0)) busy_d = 1'b1;
    end
    if (gnt_any) begin
      rr_ptr_d   = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);
      match_d    = core_hit;
      match_ch_d = core_hit ? gnt_idx : '0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      match_q    <= 1'b0;
      match_ch_q <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      match_q    <= match_d;
      match_ch_q <= match_ch_d;
      busy_q     <= busy_d;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= hist_d[i];
        fill_q[i] <= fill_d[i];
      end
    end
  end

  assign match    = match_q;
  assign match_ch = match_ch_q;
  assign busy     = busy_q;

endmodule
